mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, which sets the address and data width.
REQ-002 SHALL have these ports:
  clk  input  1  clock; all state updates on rising edge
  rst  input  1  asynchronous, active-high reset
  req0  input  1  instruction-fetch port request
  addr0  input  N  fetch byte address
  wr_ena0  input  1  fetch write (normally 0)
  wr_data0  input  N  fetch write data
  req1  input  1  data port request
  addr1  input  N  data byte address
  wr_ena1  input  1  data write
  wr_data1  input  N  data write data
  gnt0, gnt1  output  1 each  access-cycle grant
  done0, done1  output  1 each  one-cycle completion pulse
  rd_data  output  N  registered read data, shared by both ports
  busy  output  1  high when the FSM is not in S_IDLE
  mem_addr  output  N  memory address
  mem_wr_data  output  N  memory write data
  mem_wr_ena  output  1  memory write enable
  mem_rd_data  input  N  memory read data, valid the cycle after mem_addr is presented

Function
REQ-003 SHALL implement the FSM S_IDLE -> S_ACCESS -> S_DONE -> S_IDLE.
REQ-004 Any illegal state encoding SHALL go to S_IDLE on the next edge with all outputs inactive.
REQ-005 In S_IDLE with (req0|req1) = 1:
  - select the winner per REQ-012;
  - register the winner's addr, wr_ena and wr_data into mem_addr, mem_wr_ena and mem_wr_data;
  - record the winner's index;
  - go to S_ACCESS.
REQ-006 In S_IDLE with no request, the FSM SHALL stay in S_IDLE with mem_wr_ena = 0; mem_addr and mem_wr_data hold their values.
REQ-007 In S_ACCESS:
  - gnt of the winner = 1, the other gnt = 0;
  - mem_wr_ena = 1 only if the latched access is a write;
  - the next state is always S_DONE.
REQ-008 On the S_ACCESS -> S_DONE edge:
  - for a read, rd_data <= mem_rd_data;
  - for a write, rd_data holds its value;
  - mem_wr_ena <= 0.
REQ-009 In S_DONE, done of the winner = 1 for exactly one cycle, then the FSM returns to S_IDLE.
REQ-010 Latency SHALL be as follows:
  - a request sampled at edge k gives gnt high during cycle k..k+1 and done high during cycle k+1..k+2;
  - minimum spacing between accesses is 3 cycles.
REQ-011 A requester SHALL hold req and its operands until its done; deasserting req after S_IDLE has sampled it does not abort the transaction, which completes normally.
REQ-012 Arbitration: if exactly one port requests, that port wins; if both request, the winner follows the Configuration section.
REQ-013 Requests arriving during S_ACCESS or S_DONE SHALL wait for S_IDLE; a port never loses a held request permanently when round-robin is enabled.
REQ-014 done0 and done1 SHALL never be high together, and gnt0 and gnt1 SHALL never be high together.
REQ-015 Addresses SHALL pass through unmodified: no alignment check and no wrap handling, so 32'hFFFFFFFC is presented as-is.

Reset
REQ-016 While rst = 1, regardless of clk:
  - state = S_IDLE;
  - gnt0, gnt1, done0, done1, busy and mem_wr_ena = 0;
  - mem_addr, mem_wr_data and rd_data = 0;
  - the round-robin pointer points at port 1 as last served.
REQ-017 Reset asserted mid-transaction SHALL abort it: no done pulse and immediate mem_wr_ena = 0; the first edge after release evaluates from S_IDLE.

Configuration
REQ-018 Macro MEM_ARB_ROUND_ROBIN_EN:
  - defined: on conflict, the port not served most recently wins; the pointer updates at each S_ACCESS entry.
  - undefined: fixed priority, port 1 (data) always beats port 0; the pointer logic is absent.

Verification
REQ-019 Reset, then req0 = 1, addr0 = 32'h00400000, memory returns 32'h2008000A → gnt0 high 1 cycle, mem_addr = 32'h00400000, done0 high 1 cycle, rd_data = 32'h2008000A, mem_wr_ena never high.
REQ-020 req1 = 1, wr_ena1 = 1, addr1 = 32'h10010000, wr_data1 = 32'hDEADBEEF → mem_wr_ena high exactly during S_ACCESS with that address and data, done1 pulses, rd_data unchanged.
REQ-021 req0 = req1 = 1 held for 4 transactions:
  - with MEM_ARB_ROUND_ROBIN_EN, grant order is 0, 1, 0, 1;
  - without it, grant order is 1, 1, 1, 1 and done0 never pulses.
REQ-022 Assert rst in S_ACCESS of a write → mem_wr_ena falls without waiting for clk, no done pulse, busy = 0; after release a pending req0 is granted 1 cycle later.
REQ-023 req1 deasserted the cycle after S_IDLE sampled it → transaction still completes with done1; back-to-back req0 arriving in S_DONE is granted in the following S_IDLE, giving 3-cycle spacing.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port (fetch/data) arbiter in front of a single memory.
// Each access runs IDLE -> ACCESS -> DONE. Port 1 wins conflicts by default.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to resolve conflicts
// round-robin instead.
module mem_port_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [N-1:0] addr0,
  input  logic         wr_ena0,
  input  logic [N-1:0] wr_data0,
  input  logic         req1,
  input  logic [N-1:0] addr1,
  input  logic         wr_ena1,
  input  logic [N-1:0] wr_data1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [N-1:0] rd_data,
  output logic         busy,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wr_data,
  output logic         mem_wr_ena,
  input  logic [N-1:0] mem_rd_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_DONE   = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   win;      // latched winner index of the current transaction
  logic   win_nxt;  // winner among the requests sampled this cycle

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic   last_srv; // port served most recently

  // Remember which port entered S_ACCESS last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_srv <= 1'b1;
    end else if (state == S_IDLE && (req0 || req1)) begin
      last_srv <= win_nxt;
    end
  end
`endif

  // Arbitration among the currently asserted requests
  always_comb begin
    win_nxt = 1'b0;
    if (req0 && req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win_nxt = ~last_srv;
`else
      win_nxt = 1'b1;
`endif
    end else begin
      win_nxt = req1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:   state_nxt = (req0 || req1) ? S_ACCESS : S_IDLE;
      S_ACCESS: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Grant/done/busy decode from the state and the latched winner
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    done0 = 1'b0;
    done1 = 1'b0;
    busy  = 1'b0;
    case (state)
      S_ACCESS: begin
        gnt0 = ~win;
        gnt1 = win;
        busy = 1'b1;
      end
      S_DONE: begin
        done0 = ~win;
        done1 = win;
        busy  = 1'b1;
      end
      default: ;
    endcase
  end

  // Memory-side registers and read data capture.
  // mem_wr_ena doubles as the "latched access is a write" flag while in
  // S_ACCESS, so the read capture keys off it directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_wr_ena  <= 1'b0;
      rd_data     <= '0;
      win         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            mem_addr    <= win_nxt ? addr1 : addr0;
            mem_wr_data <= win_nxt ? wr_data1 : wr_data0;
            mem_wr_ena  <= win_nxt ? wr_ena1 : wr_ena0;
            win         <= win_nxt;
          end else begin
            mem_wr_ena  <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (!mem_wr_ena) begin
            rd_data <= mem_rd_data;
          end
          mem_wr_ena <= 1'b0;
        end
        default: begin
          mem_wr_ena <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter.
// Transaction-level reference model: winner chosen from the arbitration rules,
// expected read data from a simple address-hash memory model.
module tb_mem_port_arbiter;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, wr_ena0, wr_ena1;
  logic [N-1:0] addr0, addr1, wr_data0, wr_data1;
  logic         gnt0, gnt1, done0, done1, busy, mem_wr_ena;
  logic [N-1:0] rd_data, mem_addr, mem_wr_data, mem_rd_data;

  logic         rd_override_en;
  logic [N-1:0] rd_override;

  int           checks   = 0;
  int           failures = 0;
  int           last_served = 1;
  logic [N-1:0] exp_rd = '0;

  mem_port_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .wr_ena0(wr_ena0), .wr_data0(wr_data0),
    .req1(req1), .addr1(addr1), .wr_ena1(wr_ena1), .wr_data1(wr_data1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rd_data(rd_data), .busy(busy),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_ena(mem_wr_ena),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] memf(input logic [N-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A3C3C;
  endfunction

  assign mem_rd_data = rd_override_en ? rd_override : memf(mem_addr);

  // Winner from the arbitration rules: sole requester wins; on conflict the
  // configured policy decides.
  function automatic int pick(input bit r0, input bit r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return (last_served == 0) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 0; req1 = 0; wr_ena0 = 0; wr_ena1 = 0;
    addr0 = '0; addr1 = '0; wr_data0 = '0; wr_data1 = '0;
    rd_override_en = 0; rd_override = '0;
    #1;
    checks++; if ({gnt0, gnt1, done0, done1, busy, mem_wr_ena} !== 6'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=000000", {gnt0, gnt1, done0, done1, busy, mem_wr_ena}); end
    checks++; if ({mem_addr, mem_wr_data, rd_data} !== '0) begin failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", mem_addr, mem_wr_data, rd_data); end
    req0 = 1;
    tick();
    checks++; if (busy !== 1'b0 || gnt0 !== 1'b0) begin failures++; $display("FAIL reset_hold busy=%b gnt0=%b exp=0/0", busy, gnt0); end
    req0 = 0;
    @(negedge clk) rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_read();
    req0 = 1; addr0 = 32'h00400000; wr_ena0 = 0; wr_data0 = 32'h11111111;
    rd_override_en = 1; rd_override = 32'h2008000A;
    checks++; if (mem_wr_ena !== 1'b0) begin failures++; $display("FAIL read_idle_wr got=%b exp=0", mem_wr_ena); end
    tick();
    checks++; if ({gnt0, gnt1} !== 2'b10) begin failures++; $display("FAIL read_gnt got=%b exp=10", {gnt0, gnt1}); end
    checks++; if (mem_addr !== 32'h00400000) begin failures++; $display("FAIL read_addr got=%h exp=00400000", mem_addr); end
    checks++; if (mem_wr_ena !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL read_access we=%b busy=%b exp=0/1", mem_wr_ena, busy); end
    tick();
    checks++; if ({done0, done1, gnt0} !== 3'b100) begin failures++; $display("FAIL read_done got=%b exp=100", {done0, done1, gnt0}); end
    checks++; if (rd_data !== 32'h2008000A) begin failures++; $display("FAIL read_data got=%h exp=2008000a", rd_data); end
    req0 = 0; last_served = 0; exp_rd = 32'h2008000A;
    tick();
    checks++; if ({done0, busy, mem_wr_ena} !== 3'b000) begin failures++; $display("FAIL read_end got=%b exp=000", {done0, busy, mem_wr_ena}); end
    rd_override_en = 0;
  endtask

  task automatic test_write();
    req1 = 1; wr_ena1 = 1; addr1 = 32'h10010000; wr_data1 = 32'hDEADBEEF;
    tick();
    checks++; if ({gnt0, gnt1, mem_wr_ena} !== 3'b011) begin failures++; $display("FAIL write_access got=%b exp=011", {gnt0, gnt1, mem_wr_ena}); end
    checks++; if (mem_addr !== 32'h10010000 || mem_wr_data !== 32'hDEADBEEF) begin failures++; $display("FAIL write_bus got=%h/%h exp=10010000/deadbeef", mem_addr, mem_wr_data); end
    tick();
    checks++; if ({done0, done1, mem_wr_ena} !== 3'b010) begin failures++; $display("FAIL write_done got=%b exp=010", {done0, done1, mem_wr_ena}); end
    checks++; if (rd_data !== exp_rd) begin failures++; $display("FAIL write_rd_hold got=%h exp=%h", rd_data, exp_rd); end
    req1 = 0; wr_ena1 = 0; last_served = 1;
    tick();
    checks++; if ({done1, busy} !== 2'b00) begin failures++; $display("FAIL write_end got=%b exp=00", {done1, busy}); end
  endtask

  task automatic test_conflict();
    logic [3:0] order;
    int w;
    order = '0;
    req0 = 1; req1 = 1; wr_ena0 = 0; wr_ena1 = 0;
    addr0 = $urandom; addr1 = $urandom;
    for (int t = 0; t < 4; t++) begin
      w = pick(1, 1);
      last_served = w;
      tick();
      order[t] = gnt1;
      checks++; if ({gnt1, gnt0} !== ((w == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL conflict_gnt t=%0d got=%b exp_port=%0d", t, {gnt1, gnt0}, w); end
      tick();
      exp_rd = memf((w == 1) ? addr1 : addr0);
      checks++; if ({done1, done0} !== ((w == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL conflict_done t=%0d got=%b exp_port=%0d", t, {done1, done0}, w); end
      checks++; if (rd_data !== exp_rd) begin failures++; $display("FAIL conflict_rd t=%0d got=%h exp=%h", t, rd_data, exp_rd); end
      if (t == 3) begin req0 = 0; req1 = 0; end
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL conflict_idle t=%0d busy got=%b exp=0", t, busy); end
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    checks++; if (order !== 4'b1010) begin failures++; $display("FAIL conflict_order got=%b exp=1010", order); end
`else
    checks++; if (order !== 4'b1111) begin failures++; $display("FAIL conflict_order got=%b exp=1111", order); end
`endif
  endtask

  task automatic test_reset_mid();
    req1 = 1; wr_ena1 = 1; addr1 = $urandom; wr_data1 = $urandom;
    tick();
    checks++; if (mem_wr_ena !== 1'b1) begin failures++; $display("FAIL rstmid_we_before got=%b exp=1", mem_wr_ena); end
    #3;
    rst = 1'b1; req1 = 0; wr_ena1 = 0;
    #1;
    checks++; if ({mem_wr_ena, busy, gnt1} !== 3'b000) begin failures++; $display("FAIL rstmid_async got=%b exp=000", {mem_wr_ena, busy, gnt1}); end
    req0 = 1; wr_ena0 = 0; addr0 = $urandom;
    tick();
    checks++; if ({done0, done1, busy} !== 3'b000) begin failures++; $display("FAIL rstmid_nodone got=%b exp=000", {done0, done1, busy}); end
    @(negedge clk) rst = 1'b0;
    last_served = 0; exp_rd = memf(addr0);
    tick();
    checks++; if ({gnt0, gnt1} !== 2'b10 || mem_addr !== addr0) begin failures++; $display("FAIL rstmid_regrant gnt=%b addr=%h exp=10/%h", {gnt0, gnt1}, mem_addr, addr0); end
    tick();
    checks++; if (done0 !== 1'b1 || rd_data !== exp_rd) begin failures++; $display("FAIL rstmid_done done0=%b rd=%h exp=1/%h", done0, rd_data, exp_rd); end
    req0 = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    req1 = 1; wr_ena1 = 0; addr1 = $urandom;
    tick();
    checks++; if ({gnt0, gnt1} !== 2'b01) begin failures++; $display("FAIL b2b_gnt1 got=%b exp=01", {gnt0, gnt1}); end
    req1 = 0;
    tick();
    exp_rd = memf(addr1); last_served = 1;
    checks++; if (done1 !== 1'b1 || rd_data !== exp_rd) begin failures++; $display("FAIL b2b_done1 done1=%b rd=%h exp=1/%h", done1, rd_data, exp_rd); end
    req0 = 1; wr_ena0 = 0; addr0 = 32'hFFFFFFFC;
    tick();
    checks++; if ({busy, gnt0} !== 2'b00) begin failures++; $display("FAIL b2b_idle got=%b exp=00", {busy, gnt0}); end
    tick();
    checks++; if (gnt0 !== 1'b1 || mem_addr !== 32'hFFFFFFFC) begin failures++; $display("FAIL b2b_gnt0 gnt0=%b addr=%h exp=1/fffffffc", gnt0, mem_addr); end
    tick();
    exp_rd = memf(32'hFFFFFFFC); last_served = 0;
    checks++; if (done0 !== 1'b1 || rd_data !== exp_rd) begin failures++; $display("FAIL b2b_done0 done0=%b rd=%h exp=1/%h", done0, rd_data, exp_rd); end
    req0 = 0;
    tick();
  endtask

  task automatic test_random();
    bit r0, r1, isw, have_ma;
    int w;
    logic [N-1:0] a, d, exp_ma, exp_md;
    have_ma = 0; exp_ma = '0; exp_md = '0;
    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
      req0 = r0; req1 = r1;
      wr_ena0 = 1'($urandom_range(0, 1)); wr_ena1 = 1'($urandom_range(0, 1));
      addr0 = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC : $urandom;
      addr1 = $urandom; wr_data0 = $urandom; wr_data1 = $urandom;
      if (!r0 && !r1) begin
        tick();
        checks++; if ({busy, mem_wr_ena, gnt0, gnt1} !== 4'b0000) begin failures++; $display("FAIL rand_idle i=%0d got=%b exp=0000", i, {busy, mem_wr_ena, gnt0, gnt1}); end
        if (have_ma) begin
          checks++; if (mem_addr !== exp_ma || mem_wr_data !== exp_md) begin failures++; $display("FAIL rand_idle_hold i=%0d got=%h/%h exp=%h/%h", i, mem_addr, mem_wr_data, exp_ma, exp_md); end
        end
      end else begin
        w = pick(r0, r1);
        last_served = w;
        a = (w == 1) ? addr1 : addr0;
        d = (w == 1) ? wr_data1 : wr_data0;
        isw = (w == 1) ? wr_ena1 : wr_ena0;
        exp_ma = a; exp_md = d; have_ma = 1;
        tick();
        checks++; if ({gnt1, gnt0} !== ((w == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rand_gnt i=%0d got=%b exp_port=%0d", i, {gnt1, gnt0}, w); end
        checks++; if (mem_addr !== a || mem_wr_ena !== isw) begin failures++; $display("FAIL rand_bus i=%0d got=%h/%b exp=%h/%b", i, mem_addr, mem_wr_ena, a, isw); end
        if (isw) begin
          checks++; if (mem_wr_data !== d) begin failures++; $display("FAIL rand_wdata i=%0d got=%h exp=%h", i, mem_wr_data, d); end
        end
        tick();
        if (!isw) exp_rd = memf(a);
        checks++; if ({done1, done0, mem_wr_ena} !== ((w == 1) ? 3'b100 : 3'b010)) begin failures++; $display("FAIL rand_done i=%0d got=%b exp_port=%0d", i, {done1, done0, mem_wr_ena}, w); end
        checks++; if (rd_data !== exp_rd) begin failures++; $display("FAIL rand_rd i=%0d got=%h exp=%h", i, rd_data, exp_rd); end
        req0 = 0; req1 = 0;
        tick();
        checks++; if ({busy, done0, done1} !== 3'b000) begin failures++; $display("FAIL rand_end i=%0d got=%b exp=000", i, {busy, done0, done1}); end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_conflict();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
